// File: rtl/ram_write_buffer_pkg.sv
// Shared constants and entry layout for the store buffer that sits in front of ram_controller.
package ram_write_buffer_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/ram_write_buffer_entry.sv
// One store-buffer slot: a {address, data} register with write enable.
module ram_write_buffer_entry
    import ram_write_buffer_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      we,
    input  wb_entry_t d,
    output wb_entry_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram_write_buffer.sv
// Store FIFO feeding ram_controller: drains one store per idle cycle and holds
// D-cache misses back until every queued store has reached RAM.
module ram_write_buffer
    import ram_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              store_valid,
    input  logic [ADDR_W-1:0] store_address,
    input  logic [DATA_W-1:0] store_data,
    output logic              store_ready,
    output logic              buffer_empty,
    input  logic              i_cache_updating,
    input  logic              d_cache_updating,
    input  logic              d_cache_miss_in,
    output logic              d_cache_miss,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_write_data
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             controller_idle;
    logic             enqueue;
    logic             dequeue;
    wb_entry_t        store_entry;
    wb_entry_t        head_entry;
    wb_entry_t        entry_q [DEPTH];

    // Ready and write strobe look only at registered count, so a store
    // enqueued this cycle cannot be written to RAM until the next one.
    assign store_ready     = (count != FULL_COUNT);
    assign buffer_empty    = (count == '0);
    assign controller_idle = ~i_cache_updating & ~d_cache_updating;
    assign enqueue         = store_valid & store_ready;
    assign ram_write       = ~buffer_empty & controller_idle;
    assign dequeue         = ram_write;

    // Stores win over D-fills: a miss only reaches the controller once drained.
    assign d_cache_miss    = d_cache_miss_in & buffer_empty;

    assign store_entry.address = store_address;
    assign store_entry.data    = store_data;

    assign head_entry        = entry_q[rd_ptr];
    assign ram_write_address = head_entry.address;
    assign ram_write_data    = head_entry.data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        ram_write_buffer_entry u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (enqueue && (wr_ptr == PTR_W'(i))),
            .d     (store_entry),
            .q     (entry_q[i])
        );
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enqueue) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (dequeue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enqueue, dequeue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
